demux_1x2: RTL and testbench
============================

DEMUX_1X2 -- requirements
Module: demux_1x2

Interface
REQ-001 Parameter WIDTH, default 1, data width of input E and outputs Out1/Out2.
REQ-002 Parameter CNT_W, default 8, width of each routing-event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Sel  input  1  route select; 0 selects Out1, 1 selects Out2.
REQ-006 E  input  WIDTH  data/enable to be routed.
REQ-007 clr  input  1  synchronous clear of both counters.
REQ-008 Out1  output  WIDTH  registered copy of E when Sel=0, else 0.
REQ-009 Out2  output  WIDTH  registered copy of E when Sel=1, else 0.
REQ-010 cnt1  output  CNT_W  count of nonzero E cycles routed to Out1.
REQ-011 cnt2  output  CNT_W  count of nonzero E cycles routed to Out2.
REQ-012 Port order SHALL be clk, rst_n, Sel, E, clr, Out2, Out1, cnt1, cnt2.

Function
REQ-013 On each rising clk edge, Out1 SHALL load (Sel==0) ? E : 0.
REQ-014 On each rising clk edge, Out2 SHALL load (Sel==1) ? E : 0.
REQ-015 Latency SHALL be exactly one clock from Sel/E sample to Out1/Out2.
REQ-016 Out1 and Out2 SHALL never both be nonzero in the same cycle.
REQ-017 E==0 SHALL drive both outputs to 0 at the next edge regardless of Sel.
REQ-018 Routing SHALL be bitwise for WIDTH>1: unselected output all zeros, selected output equals E bit-for-bit.
REQ-019 cnt1 SHALL increment by 1 on an edge where Sel==0, E!=0 and clr==0.
REQ-020 cnt2 SHALL increment by 1 on an edge where Sel==1, E!=0 and clr==0.
REQ-021 Counters SHALL saturate at all-ones (2^CNT_W-1) and never wrap.
REQ-022 clr==1 SHALL set cnt1 and cnt2 to 0 at the edge, taking priority over increment; clr SHALL NOT affect Out1/Out2.
REQ-023 No handshake; every cycle's Sel/E is accepted; no internal state beyond output and counter registers.
REQ-024 Instances SHALL be cascadable (e.g. a 1x4 tree): each stage adds one clock of latency.

Reset
REQ-025 rst_n low SHALL immediately (without clk) force Out1, Out2, cnt1, cnt2 to 0.
REQ-026 While rst_n low, all registers SHALL hold 0; Sel, E, clr ignored.
REQ-027 First capture after rst_n deasserts SHALL occur at the first rising clk edge with rst_n high.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight value; outputs do not reflect the last sampled E.

Verification
REQ-029 WIDTH=1: Sel=0,E=1 -> next cycle Out1=1,Out2=0; Sel=1,E=1 -> Out1=0,Out2=1.
REQ-030 WIDTH=1: Sel=0,E=0 then Sel=1,E=0 -> Out1=0,Out2=0 both cycles; counters unchanged.
REQ-031 WIDTH=8: Sel=1,E=8'hA5 -> Out2=8'hA5,Out1=8'h00, cnt2 increments by 1.
REQ-032 CNT_W=2: 5 cycles Sel=0,E=1 -> cnt1 sequence 1,2,3,3,3; clr=1 one cycle -> cnt1=0, Out1 still 1.
REQ-033 Outputs nonzero, rst_n pulled low between edges -> Out1,Out2,cnt1,cnt2=0 immediately; release -> routing resumes next edge.
REQ-034 Two instances cascaded as 1x4 (Sel[1] first stage): Sel=2'b10,E=1 -> third output high after 2 clocks, others 0.

Source files
------------

// File: rtl/demux_1x2.sv
// 1-to-2 registered demultiplexer with per-output routing-event counters.
// Each stage adds one clock of latency, so instances can be cascaded into trees.
module demux_1x2 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Sel,
    input  logic [WIDTH-1:0] E,
    input  logic             clr,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out1,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [WIDTH-1:0] out1_d, out1_q;
    logic [WIDTH-1:0] out2_d, out2_q;
    logic [CNT_W-1:0] cnt1_d, cnt1_q;
    logic [CNT_W-1:0] cnt2_d, cnt2_q;
    logic             e_nz;

    always_comb begin
        e_nz   = |E;
        out1_d = Sel ? '0 : E;
        out2_d = Sel ? E : '0;

        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        // clr wins over increment; counters stick at all-ones
        if (clr) begin
            cnt1_d = '0;
            cnt2_d = '0;
        end else if (e_nz) begin
            if (!Sel && (cnt1_q != CntMax)) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
            if (Sel && (cnt2_q != CntMax)) begin
                cnt2_d = cnt2_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_q <= '0;
            out2_q <= '0;
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign Out1 = out1_q;
    assign Out2 = out2_q;
    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;

endmodule

// File: tb/tb_demux_1x2.sv
// Bench for demux_1x2: 8-bit and 1-bit instances plus a two-stage 1x4 cascade,
// compared every cycle against a behavioural model under random stimulus.
module tb_demux_1x2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       clr;
    logic [7:0] e;
    logic [1:0] sel2;

    logic [7:0] o1, o2;
    logic [2:0] c1, c2;
    logic       w_o1, w_o2;
    logic [1:0] w_c1, w_c2;
    logic       s1_o1, s1_o2;
    logic [3:0] leaf;
    logic [7:0] s1_c1, s1_c2, sa_c1, sa_c2, sb_c1, sb_c2;

    int n_checks = 0;
    int n_pass   = 0;

    int m_o1[2], m_o2[2], m_c1[2], m_c2[2];
    int m_s1[2];
    int m_leaf[4];

    always #5 clk = ~clk;

    demux_1x2 #(.WIDTH(8), .CNT_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .Sel(sel), .E(e), .clr(clr),
        .Out2(o2), .Out1(o1), .cnt1(c1), .cnt2(c2)
    );

    demux_1x2 #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst_n(rst_n), .Sel(sel), .E(e[0]), .clr(clr),
        .Out2(w_o2), .Out1(w_o1), .cnt1(w_c1), .cnt2(w_c2)
    );

    demux_1x2 #(.WIDTH(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .Sel(sel2[1]), .E(e[0]), .clr(clr),
        .Out2(s1_o2), .Out1(s1_o1), .cnt1(s1_c1), .cnt2(s1_c2)
    );

    demux_1x2 #(.WIDTH(1)) u_s2a (
        .clk(clk), .rst_n(rst_n), .Sel(sel2[0]), .E(s1_o1), .clr(clr),
        .Out2(leaf[1]), .Out1(leaf[0]), .cnt1(sa_c1), .cnt2(sa_c2)
    );

    demux_1x2 #(.WIDTH(1)) u_s2b (
        .clk(clk), .rst_n(rst_n), .Sel(sel2[0]), .E(s1_o2), .clr(clr),
        .Out2(leaf[3]), .Out1(leaf[2]), .cnt1(sb_c1), .cnt2(sb_c2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_o1[k] = 0; m_o2[k] = 0; m_c1[k] = 0; m_c2[k] = 0; m_s1[k] = 0;
        end
        for (int i = 0; i < 4; i++) m_leaf[i] = 0;
    endtask

    // One clock edge with rst_n high, using the inputs held across that edge.
    task automatic model_edge();
        int ev[2];
        int cmax[2];
        ev[0] = int'(e);
        ev[1] = int'(e[0]);
        cmax[0] = 7;
        cmax[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_o1[k] = sel ? 0 : ev[k];
            m_o2[k] = sel ? ev[k] : 0;
            if (clr) begin
                m_c1[k] = 0;
                m_c2[k] = 0;
            end else if (ev[k] != 0) begin
                if (sel) m_c2[k] = (m_c2[k] < cmax[k]) ? m_c2[k] + 1 : cmax[k];
                else     m_c1[k] = (m_c1[k] < cmax[k]) ? m_c1[k] + 1 : cmax[k];
            end
        end
        for (int j = 0; j < 2; j++) begin
            for (int kk = 0; kk < 2; kk++) begin
                m_leaf[2*j+kk] = (int'(sel2[0]) == kk) ? m_s1[j] : 0;
            end
        end
        for (int j = 0; j < 2; j++) begin
            m_s1[j] = (int'(sel2[1]) == j) ? int'(e[0]) : 0;
        end
    endtask

    task automatic check_all();
        logic [3:0] le;
        for (int i = 0; i < 4; i++) le[i] = m_leaf[i][0];
        check("out1",   32'(o1), m_o1[0]);
        check("out2",   32'(o2), m_o2[0]);
        check("cnt1",   32'(c1), m_c1[0]);
        check("cnt2",   32'(c2), m_c2[0]);
        check("excl",   32'((o1 != 0) && (o2 != 0)), 0);
        check("w_out1", 32'(w_o1), m_o1[1]);
        check("w_out2", 32'(w_o2), m_o2[1]);
        check("w_cnt1", 32'(w_c1), m_c1[1]);
        check("w_cnt2", 32'(w_c2), m_c2[1]);
        check("leaf",   32'(leaf), 32'(le));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 3, 3};
        rst_n = 1'b1; sel = 1'b0; e = 8'h00; clr = 1'b0; sel2 = 2'b00;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all();

        // Inputs are ignored while reset is held
        sel = 1'b1; e = 8'hFF; sel2 = 2'b11;
        tick();
        tick();
        rst_n = 1'b1;

        sel = 1'b0; e = 8'h01; sel2 = 2'b00;
        tick();
        check("r029_o1", 32'(o1), 1);
        check("r029_o2", 32'(o2), 0);
        sel = 1'b1;
        tick();
        check("r029b_o1", 32'(o1), 0);
        check("r029b_o2", 32'(o2), 1);

        sel = 1'b0; e = 8'h00;
        tick();
        sel = 1'b1;
        tick();
        check("r030_o", 32'({o1, o2}), 0);
        check("r030_c", 32'({c1, c2}), 32'({3'd1, 3'd1}));

        e = 8'hA5;
        tick();
        check("r031_o2", 32'(o2), 32'h A5);
        check("r031_o1", 32'(o1), 0);
        check("r031_c2", 32'(c2), 2);

        clr = 1'b1;
        tick();
        clr = 1'b0; sel = 1'b0; e = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("r032_seq", 32'(w_c1), exp_seq[i]);
        end
        clr = 1'b1;
        tick();
        check("r032_clr_c", 32'(w_c1), 0);
        check("r032_clr_o", 32'(w_o1), 1);
        clr = 1'b0;

        e = 8'h3C; sel = 1'b1;
        tick();
        reset_pulse();
        check("r033_rst", 32'({o1, o2, c1, c2}), 0);
        tick();
        check("r033_resume", 32'(o2), 32'h3C);

        e = 8'h00; sel2 = 2'b00;
        tick();
        tick();
        sel2 = 2'b10; e = 8'h01;
        tick();
        check("r034_lat1", 32'(leaf), 0);
        e = 8'h00;
        tick();
        check("r034_leaf", 32'(leaf), 32'h4);

        for (int n = 0; n < 400; n++) begin
            sel  = 1'($urandom);
            e    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            clr  = ($urandom_range(0, 15) == 0);
            sel2 = 2'($urandom);
            tick();
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
